photo_capture_sequencer: RTL and testbench
==========================================

PHOTO_CAPTURE_SEQUENCER -- requirements
Module: photo_capture_sequencer

Interface
REQ-001 SHALL have parameter NUM_PHOTOS, default 4, photos per session (1..4).
REQ-002 SHALL have parameter COUNT_SECS, default 3, countdown seconds per photo (1..7).
REQ-003 SHALL have parameter FRAMES_PER_SEC, default 60, new_frame_in pulses per countdown second.
REQ-004 SHALL have parameter GAP_FRAMES, default 30, idle frames between photos (>=1).
REQ-005 SHALL have port clk_in  input  1  system pixel clock; the block's only clock.
REQ-006 SHALL have port rst_in  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port start_in  input  1  level; the rising edge starts a session.
REQ-008 SHALL have port filter_in  input  3  filter selection, 0..5.
REQ-009 SHALL have port new_frame_in  input  1  one-cycle pulse at each frame start.
REQ-010 SHALL have port capture_ack_in  input  1  frame writer accepted capture request.
REQ-011 SHALL have port abort_in  input  1  level; cancels the session.
REQ-012 SHALL have port capture_req_out  output  1  request to freeze/store current frame.
REQ-013 SHALL have port photo_idx_out  output  2  storage slot of current photo.
REQ-014 SHALL have port filter_out  output  3  filter latched at session start.
REQ-015 SHALL have port countdown_out  output  3  seconds remaining for overlay; 0 outside COUNTDOWN.
REQ-016 SHALL have port flash_out  output  1  high during CAPTURE for the white-flash overlay.
REQ-017 SHALL have ports busy_out and done_out  output  1 each  session active / session complete.

Function
REQ-018 SHALL implement states IDLE, COUNTDOWN, CAPTURE, GAP, DONE; all outputs registered.
REQ-019 SHALL detect start rising edge as start_in & ~start_q, with start_q registered every cycle.
REQ-020 IDLE: on start edge, SHALL latch filter_in (values 6/7 clamp to 0), clear photo_idx_out, load frame and second counters, and go to COUNTDOWN next cycle.
REQ-021 COUNTDOWN: countdown_out SHALL load COUNT_SECS and decrement once per FRAMES_PER_SEC new_frame_in pulses; reaching 0 SHALL move to CAPTURE on that same edge.
REQ-022 CAPTURE: capture_req_out and flash_out SHALL be high continuously until the capture_ack_in cycle; the ack is sampled only while req is high.
REQ-023 When ack is seen, req SHALL drop the next cycle; if photo_idx_out==NUM_PHOTOS-1 then go to DONE, else increment photo_idx_out and go to GAP.
REQ-024 GAP: SHALL count GAP_FRAMES new_frame_in pulses, then reload counters and go to COUNTDOWN.
REQ-025 DONE: done_out SHALL be held high; a start edge SHALL begin a new session exactly as from IDLE.
REQ-026 busy_out SHALL be high in COUNTDOWN, CAPTURE and GAP only.
REQ-027 Start edges in COUNTDOWN, CAPTURE or GAP SHALL be ignored.
REQ-028 abort_in high in any state SHALL force IDLE next cycle, clear req/flash/countdown/done, and take priority over ack and start.
REQ-029 new_frame_in pulses outside COUNTDOWN/GAP SHALL be ignored; counters SHALL never wrap.

Reset
REQ-030 Asserted rst_in SHALL immediately force IDLE, clear all outputs and counters to 0, and clear start_q to 0. A start_in held high through reset SHALL therefore produce an edge.
REQ-031 Deassertion SHALL be synchronised externally; no session starts without a start edge after reset.

Structure
REQ-032 State enum and filter count (6) SHALL live in the shared photobooth package.
REQ-033 A frame_tick_counter sub-module (load, count new_frame_in, terminal flag) SHALL be shared by the COUNTDOWN and GAP states.

Verification
REQ-034 Default params, start edge, 180 frames -> countdown 3,2,1 each lasting 60 frames, then req high; ack after 5 cycles -> req low next cycle, idx=1.
REQ-035 Four acks -> done_out=1, busy_out=0, idx=3; a new start edge -> idx=0 and COUNTDOWN again.
REQ-036 filter_in=4 at start then changed to 1 -> filter_out stays 4; filter_in=7 -> filter_out=0.
REQ-037 abort_in during CAPTURE in the same cycle as ack -> IDLE, req=0, idx unchanged by the ack.
REQ-038 rst_in low mid-GAP -> all outputs 0 at once; start held high on release -> session starts.
REQ-039 Start edge during COUNTDOWN -> no restart; countdown continues uninterrupted.

Source files
------------

// File: rtl/photo_capture_sequencer_pkg.sv
// Shared photobooth definitions: sequencer states, filter count and the
// filter-selection clamp used when a session latches its filter.
package photo_capture_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_GAP       = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam int NUM_FILTERS = 6;

  // Unsupported filter codes fall back to the pass-through filter 0.
  function automatic logic [2:0] clamp_filter(input logic [2:0] sel);
    return (sel >= 3'(NUM_FILTERS)) ? 3'd0 : sel;
  endfunction

endpackage

// File: rtl/photo_capture_sequencer_frame_tick_counter.sv
// Loadable down-counter of new_frame_in pulses; flags the pulse that exhausts
// the loaded count. Saturates at zero so it never wraps.
module frame_tick_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  input  logic             new_frame_in,
  output logic             terminal
);

  logic [WIDTH-1:0] count;
  logic             tick;

  assign tick     = enable & new_frame_in & (count != '0);
  assign terminal = tick & (count == WIDTH'(1));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick) begin
      count <= count - WIDTH'(1);
    end
  end

endmodule

// File: rtl/photo_capture_sequencer.sv
// Photobooth session sequencer: countdown overlay, capture handshake with the
// frame writer, inter-photo gap and session completion. All outputs registered.
module photo_capture_sequencer
  import photo_capture_sequencer_pkg::*;
#(
  parameter int NUM_PHOTOS     = 4,
  parameter int COUNT_SECS     = 3,
  parameter int FRAMES_PER_SEC = 60,
  parameter int GAP_FRAMES     = 30
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [2:0] filter_in,
  input  logic       new_frame_in,
  input  logic       capture_ack_in,
  input  logic       abort_in,
  output logic       capture_req_out,
  output logic [1:0] photo_idx_out,
  output logic [2:0] filter_out,
  output logic [2:0] countdown_out,
  output logic       flash_out,
  output logic       busy_out,
  output logic       done_out,
  output logic [2:0] state_out
);

  localparam int CNT_MAX = (FRAMES_PER_SEC > GAP_FRAMES) ? FRAMES_PER_SEC : GAP_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t         state, state_n;
  logic           start_q, start_edge;
  logic [1:0]     idx_n;
  logic [2:0]     filter_n, cd_n;
  logic           req_n, flash_n, busy_n, done_n;
  logic           cnt_load, cnt_enable, cnt_terminal;
  logic [CW-1:0]  cnt_value;

  assign start_edge = start_in & ~start_q;
  assign state_out  = state;

  frame_tick_counter #(.WIDTH(CW)) u_frame_tick_counter (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .load         (cnt_load),
    .load_value   (cnt_value),
    .enable       (cnt_enable),
    .new_frame_in (new_frame_in),
    .terminal     (cnt_terminal)
  );

  // Capture handshake: capture_req_out rises on entry to CAPTURE and stays high
  // until capture_ack_in is sampled high with it; req drops on the following edge.
  always_comb begin
    state_n    = state;
    idx_n      = photo_idx_out;
    filter_n   = filter_out;
    cd_n       = countdown_out;
    req_n      = capture_req_out;
    flash_n    = flash_out;
    busy_n     = busy_out;
    done_n     = done_out;
    cnt_load   = 1'b0;
    cnt_value  = CW'(FRAMES_PER_SEC);
    cnt_enable = 1'b0;

    if (abort_in) begin
      state_n = ST_IDLE;
      req_n   = 1'b0;
      flash_n = 1'b0;
      cd_n    = 3'd0;
      busy_n  = 1'b0;
      done_n  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            filter_n = clamp_filter(filter_in);
            idx_n    = 2'd0;
            cnt_load = 1'b1;
            cd_n     = 3'(COUNT_SECS);
            busy_n   = 1'b1;
            done_n   = 1'b0;
            state_n  = ST_COUNTDOWN;
          end
        end
        ST_COUNTDOWN: begin
          cnt_enable = 1'b1;
          if (cnt_terminal) begin
            cnt_load = 1'b1;
            cd_n     = countdown_out - 3'd1;
            if (countdown_out == 3'd1) begin
              req_n   = 1'b1;
              flash_n = 1'b1;
              state_n = ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (capture_ack_in && capture_req_out) begin
            req_n   = 1'b0;
            flash_n = 1'b0;
            if (photo_idx_out == 2'(NUM_PHOTOS - 1)) begin
              busy_n  = 1'b0;
              done_n  = 1'b1;
              state_n = ST_DONE;
            end else begin
              idx_n     = photo_idx_out + 2'd1;
              cnt_load  = 1'b1;
              cnt_value = CW'(GAP_FRAMES);
              state_n   = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          cnt_enable = 1'b1;
          if (cnt_terminal) begin
            cnt_load = 1'b1;
            cd_n     = 3'(COUNT_SECS);
            state_n  = ST_COUNTDOWN;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_IDLE;
      start_q         <= 1'b0;
      photo_idx_out   <= 2'd0;
      filter_out      <= 3'd0;
      countdown_out   <= 3'd0;
      capture_req_out <= 1'b0;
      flash_out       <= 1'b0;
      busy_out        <= 1'b0;
      done_out        <= 1'b0;
    end else begin
      state           <= state_n;
      start_q         <= start_in;
      photo_idx_out   <= idx_n;
      filter_out      <= filter_n;
      countdown_out   <= cd_n;
      capture_req_out <= req_n;
      flash_out       <= flash_n;
      busy_out        <= busy_n;
      done_out        <= done_n;
    end
  end

endmodule

// File: tb/tb_photo_capture_sequencer.sv
// Directed session walk-through with randomized frame spacing, ack delays and
// filters, compared against a frame-counting model of a photobooth session.
module tb_photo_capture_sequencer;

  localparam int NP  = 4;
  localparam int CS  = 3;
  localparam int FPS = 60;
  localparam int GAP = 30;

  localparam int P_IDLE = 0, P_CD = 1, P_CAP = 2, P_GAP = 3, P_DONE = 4;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       start_in, new_frame_in, capture_ack_in, abort_in;
  logic [2:0] filter_in;
  logic       capture_req_out, flash_out, busy_out, done_out;
  logic [1:0] photo_idx_out;
  logic [2:0] filter_out, countdown_out, state_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Session model
  int         m_phase, m_frames;
  logic       m_req, m_flash, m_busy, m_done;
  logic [1:0] m_idx;
  logic [2:0] m_filter, m_cd;

  photo_capture_sequencer #(
    .NUM_PHOTOS(NP), .COUNT_SECS(CS), .FRAMES_PER_SEC(FPS), .GAP_FRAMES(GAP)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .filter_in       (filter_in),
    .new_frame_in    (new_frame_in),
    .capture_ack_in  (capture_ack_in),
    .abort_in        (abort_in),
    .capture_req_out (capture_req_out),
    .photo_idx_out   (photo_idx_out),
    .filter_out      (filter_out),
    .countdown_out   (countdown_out),
    .flash_out       (flash_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .state_out       (state_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic cycle();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string name, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", name, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".req"},    {2'b00, capture_req_out}, {2'b00, m_req});
    chk({tag, ".flash"},  {2'b00, flash_out},       {2'b00, m_flash});
    chk({tag, ".busy"},   {2'b00, busy_out},        {2'b00, m_busy});
    chk({tag, ".done"},   {2'b00, done_out},        {2'b00, m_done});
    chk({tag, ".idx"},    {1'b0, photo_idx_out},    {1'b0, m_idx});
    chk({tag, ".filter"}, filter_out,               m_filter);
    chk({tag, ".cd"},     countdown_out,            m_cd);
  endtask

  task automatic model_clear();
    m_phase = P_IDLE; m_frames = 0;
    m_req = 0; m_flash = 0; m_busy = 0; m_done = 0;
    m_idx = 0; m_filter = 0; m_cd = 0;
  endtask

  task automatic model_start(input logic [2:0] f);
    m_filter = (f > 3'd5) ? 3'd0 : f;
    m_idx = 0; m_phase = P_CD; m_frames = 0; m_cd = 3'(CS);
    m_busy = 1; m_done = 0; m_req = 0; m_flash = 0;
  endtask

  task automatic model_abort();
    m_phase = P_IDLE; m_req = 0; m_flash = 0; m_cd = 0; m_busy = 0; m_done = 0;
  endtask

  // Countdown shown = seconds left, i.e. CS minus whole seconds of frames seen.
  task automatic model_frame();
    if (m_phase == P_CD) begin
      m_frames++;
      if (m_frames == CS * FPS) begin
        m_phase = P_CAP; m_cd = 0; m_req = 1; m_flash = 1;
      end else begin
        m_cd = 3'(CS - m_frames / FPS);
      end
    end else if (m_phase == P_GAP) begin
      m_frames++;
      if (m_frames == GAP) begin
        m_phase = P_CD; m_frames = 0; m_cd = 3'(CS);
      end
    end
  endtask

  task automatic model_ack();
    if (m_phase == P_CAP) begin
      m_req = 0; m_flash = 0;
      if (int'(m_idx) == NP - 1) begin
        m_phase = P_DONE; m_done = 1; m_busy = 0;
      end else begin
        m_idx = m_idx + 2'd1; m_phase = P_GAP; m_frames = 0;
      end
    end
  endtask

  task automatic send_frame();
    new_frame_in = 1'b1;
    cycle();
    new_frame_in = 1'b0;
    model_frame();
    repeat ($urandom_range(0, 2)) cycle();
  endtask

  task automatic start_pulse();
    start_in = 1'b1;
    cycle();
    start_in = 1'b0;
    cycle();
  endtask

  task automatic run_frames(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      send_frame();
      check_all(tag);
    end
  endtask

  task automatic ack_after(input int wait_cycles);
    for (int i = 0; i < wait_cycles; i++) begin
      cycle();
      check_all("cap_wait");
    end
    capture_ack_in = 1'b1;
    cycle();
    capture_ack_in = 1'b0;
    model_ack();
    check_all("ack");
  endtask

  initial begin
    logic [2:0] f;
    rst_in = 1'b0; start_in = 1'b0; filter_in = 3'd0;
    new_frame_in = 1'b0; capture_ack_in = 1'b0; abort_in = 1'b0;
    model_clear();
    cycle();
    check_all("reset");
    rst_in = 1'b1;
    cycle();

    // Frames and acks while idle do nothing; abort beats a simultaneous start.
    send_frame();
    capture_ack_in = 1'b1; cycle(); capture_ack_in = 1'b0;
    start_in = 1'b1; abort_in = 1'b1; cycle();
    start_in = 1'b0; abort_in = 1'b0; cycle();
    check_all("idle_ignore");

    // Session 1: filter 4 latched, later filter changes do not leak through.
    filter_in = 3'd4;
    start_in  = 1'b1;
    cycle();
    model_start(3'd4);
    check_all("start1");
    filter_in = 3'd1;
    cycle();
    start_in = 1'b0;
    check_all("start1_hold");

    run_frames(100, "cd1a");
    start_pulse();
    check_all("cd1_restart_ignored");
    run_frames(CS * FPS - 100, "cd1b");

    send_frame();
    check_all("cap1_frame_ignored");
    ack_after(5);
    capture_ack_in = 1'b1; cycle(); capture_ack_in = 1'b0;
    check_all("gap_ack_ignored");
    run_frames(GAP, "gap1");

    for (int p = 1; p < NP; p++) begin
      run_frames(CS * FPS, "cd_n");
      ack_after($urandom_range(0, 6));
      if (p < NP - 1) run_frames(GAP, "gap_n");
    end
    send_frame();
    check_all("done_frame_ignored");

    // Session 2 from DONE with an out-of-range filter, then abort racing an ack.
    filter_in = 3'd7;
    start_in  = 1'b1;
    cycle();
    start_in = 1'b0;
    model_start(3'd7);
    check_all("start2");
    run_frames(CS * FPS, "cd2");
    repeat (2) cycle();
    abort_in = 1'b1; capture_ack_in = 1'b1;
    cycle();
    abort_in = 1'b0; capture_ack_in = 1'b0;
    model_abort();
    check_all("abort_with_ack");

    // Session 3: reset in the middle of the gap with start held high.
    f = 3'($urandom_range(0, 7));
    filter_in = f;
    start_pulse();
    model_start(f);
    check_all("start3");
    run_frames(CS * FPS, "cd3");
    ack_after($urandom_range(1, 4));
    run_frames(15, "gap3");
    start_in = 1'b1;
    rst_in   = 1'b0;
    #1;
    model_clear();
    check_all("reset_mid_gap");
    cycle();
    check_all("reset_held");
    f = 3'($urandom_range(0, 5));
    filter_in = f;
    rst_in = 1'b1;
    cycle();
    model_start(f);
    check_all("start_after_reset");
    start_in = 1'b0;
    run_frames(FPS + 5, "cd4");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
